clk_line_monitor: RTL and testbench
===================================

// Module: clk_line_monitor
// PURPOSE
//  Receive-side observer for a shared clock line driven by sub_block instances.
//  Synchronises the line into the system clock domain and detects rising edges.
//  Measures the period between rising edges, tracks min/max, counts edges, and
//  flags a stuck line. Sits beside the top_block clock net as a passive sink.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser depth on line_in (>=2)
//  CNT_W        16    period counter / period output width
//  EDGE_W       32    rising-edge counter width
//  TIMEOUT      1024  cycles without an edge before stuck asserts (< 2**CNT_W)
// PORTS
//  clk           in   1       system clock; all logic on posedge
//  rst           in   1       synchronous, active-high reset
//  line_in       in   1       observed clock line (asynchronous to clk)
//  enable        in   1       1 = monitor runs; 0 = return to IDLE
//  clear_stats   in   1       1-cycle pulse: reset min/max/edge_count only
//  rise_pulse    out  1       1-cycle pulse per synchronised rising edge
//  period_valid  out  1       1-cycle pulse, period holds a new measurement
//  period        out  CNT_W   clk cycles between last two rising edges
//  min_period    out  CNT_W   smallest period since reset/clear
//  max_period    out  CNT_W   largest period since reset/clear
//  edge_count    out  EDGE_W  rising edges seen while enabled
//  stuck         out  1       level; line idle >= TIMEOUT cycles
//  stuck_level   out  1       synchronised line value when stuck asserted
// BEHAVIOUR
//  Reset: all outputs 0 except min_period = all-ones; FSM -> IDLE; sync flops 0.
//  Sync: SYNC_STAGES flops + one history flop; rise = s & ~s_d. Edge-to-
//   rise_pulse latency = SYNC_STAGES+1 clk cycles (rise_pulse registered).
//  FSM states: IDLE, ARM, MEASURE, STUCK.
//   IDLE:    enable=1 -> ARM; counter held 0.
//   ARM:     first rise -> MEASURE, counter := 1; no period_valid on first edge.
//            counter reaches TIMEOUT -> STUCK.
//   MEASURE: each clk counter += 1. On rise: period := counter, period_valid
//            pulses same cycle as rise_pulse, counter := 1; update min/max.
//            counter reaches TIMEOUT without rise -> STUCK.
//   STUCK:   stuck=1, stuck_level captured on entry; next rise -> MEASURE,
//            stuck := 0, counter := 1, no period_valid for that edge.
//   Any state: enable=0 -> IDLE next cycle; stuck cleared; stats retained.
//  Counter saturates at TIMEOUT; never wraps. period never exceeds TIMEOUT-1.
//  edge_count increments on every rise while enable=1 (all states but IDLE);
//   wraps modulo 2**EDGE_W.
//  min/max: compared against the new period in the period_valid cycle.
//  clear_stats: min := all-ones, max := 0, edge_count := 0; if coincident with
//   period_valid, the new period is the first sample (min=max=period,
//   edge_count := 1).
//  rst takes precedence over enable and clear_stats in every cycle, including
//   mid-measurement; partial period is discarded.
//  Multi-driver contention appears as X on line_in in simulation; the RTL does
//   not resolve it; the synchroniser samples whatever value is presented.
// STRUCTURE
//  Package clk_mon_pkg: typedef enum logic [1:0] mon_state_e {IDLE,ARM,MEASURE,
//   STUCK}; localparam defaults for CNT_W/EDGE_W/TIMEOUT.
//  Sub-module sync_rise_det (SYNC_STAGES): synchroniser + rising-edge pulse,
//   outputs sync level and rise. Top holds FSM, counter, stats registers.
// TESTING
//  1 line_in toggles period 10 clk, enable=1 -> first rise no period_valid; then
//    period=10 each edge, min=max=10, edge_count increments by 1 per rise.
//  2 periods 8,12,6 in sequence -> min_period=6, max_period=12, last period=6.
//  3 line_in held 1 for TIMEOUT+5 after MEASURE -> stuck=1 exactly TIMEOUT
//    cycles after last counter reset, stuck_level=1; next rise clears stuck,
//    no period_valid on it, following edge gives correct period.
//  4 clear_stats pulsed same cycle as period_valid with period 9 ->
//    min=max=9, edge_count=1.
//  5 rst asserted mid-period (counter=5) -> next cycle all outputs reset,
//    min=all-ones, FSM IDLE; re-enable -> ARM, first rise yields no period.
//  6 enable dropped during STUCK -> stuck=0 next cycle, FSM IDLE, stats held.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the clock-line monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        STUCK   = 2'd3
    } mon_state_e;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_EDGE_W      = 32;
    localparam int unsigned DEF_TIMEOUT     = 1024;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for an asynchronous line plus a rising-edge detector.
module sync_rise_det
    import clk_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;

endmodule

// File: rtl/clk_line_monitor.sv
// Passive observer of a shared clock line: edge detection, period measurement,
// min/max/edge statistics and stuck-line detection.
module clk_line_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned EDGE_W      = DEF_EDGE_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    input  logic              enable,
    input  logic              clear_stats,
    output logic              rise_pulse,
    output logic              period_valid,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  min_period,
    output logic [CNT_W-1:0]  max_period,
    output logic [EDGE_W-1:0] edge_count,
    output logic              stuck,
    output logic              stuck_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic       level;
    logic       rise;
    mon_state_e state;
    logic [CNT_W-1:0] counter;
    // Rise that counts toward edge_count, aligned with rise_pulse.
    logic       edge_hit;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .line_in(line_in),
        .level  (level),
        .rise   (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            rise_pulse   <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
            edge_hit     <= 1'b0;
        end else begin
            rise_pulse   <= rise;
            period_valid <= 1'b0;
            edge_hit     <= rise & enable & (state != IDLE);
            if (!enable) begin
                state   <= IDLE;
                counter <= '0;
                stuck   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state   <= ARM;
                        counter <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            state   <= MEASURE;
                            counter <= ONE_C;
                        end else if (counter == TIMEOUT_C) begin
                            state       <= STUCK;
                            stuck       <= 1'b1;
                            stuck_level <= level;
                        end else begin
                            counter <= counter + ONE_C;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            counter <= ONE_C;
                            // A rise in the saturated cycle is treated as a stuck exit.
                            if (counter != TIMEOUT_C) begin
                                period       <= counter;
                                period_valid <= 1'b1;
                            end
                        end else if (counter == TIMEOUT_C) begin
                            state       <= STUCK;
                            stuck       <= 1'b1;
                            stuck_level <= level;
                        end else begin
                            counter <= counter + ONE_C;
                        end
                    end
                    STUCK: begin
                        if (rise) begin
                            state   <= MEASURE;
                            stuck   <= 1'b0;
                            counter <= ONE_C;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        counter <= '0;
                        stuck   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Statistics follow the registered period, so clear_stats in the
    // period_valid cycle makes that period the first sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_period <= '1;
            max_period <= '0;
            edge_count <= '0;
        end else if (clear_stats) begin
            min_period <= period_valid ? period : '1;
            max_period <= period_valid ? period : '0;
            edge_count <= edge_hit ? EDGE_W'(1) : '0;
        end else begin
            if (period_valid) begin
                if (period < min_period) begin
                    min_period <= period;
                end
                if (period > max_period) begin
                    max_period <= period;
                end
            end
            if (edge_hit) begin
                edge_count <= edge_count + EDGE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_line_monitor.sv
// Directed bench for clk_line_monitor; periods are scoreboarded through a queue.
module tb_clk_line_monitor;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_in = 1'b0;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic        rise_pulse;
    logic        period_valid;
    logic [15:0] period;
    logic [15:0] min_period;
    logic [15:0] max_period;
    logic [31:0] edge_count;
    logic        stuck;
    logic        stuck_level;

    int          compared = 0;
    int          mismatched = 0;
    int          last_gap = 0;
    logic [15:0] exp_q[$];

    clk_line_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (16),
        .EDGE_W     (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_in     (line_in),
        .enable      (enable),
        .clear_stats (clear_stats),
        .rise_pulse  (rise_pulse),
        .period_valid(period_valid),
        .period      (period),
        .min_period  (min_period),
        .max_period  (max_period),
        .edge_count  (edge_count),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rise, high for h cycles, low for l cycles.
    task automatic line_cycle(input int h, input int l, input bit expect_period);
        if (expect_period) exp_q.push_back(16'(last_gap));
        line_in = 1'b1;
        repeat (h) @(negedge clk);
        line_in = 1'b0;
        repeat (l) @(negedge clk);
        last_gap = h + l;
    endtask

    // Scoreboard: every period_valid must match the oldest expected period.
    always @(negedge clk) begin
        if (!rst && period_valid) begin
            logic [15:0] exp_p;
            check("period_valid_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_p = exp_q.pop_front();
                check("period_value", period, exp_p);
            end
        end
    end

    initial begin
        int k;
        int nrise;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rise_pulse", rise_pulse, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_period", period, 0);
        check("rst_min", min_period, 16'hffff);
        check("rst_max", max_period, 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_stuck", stuck, 0);
        check("rst_stuck_level", stuck_level, 0);
        rst = 1'b0;
        enable = 1'b1;

        // 1: steady period 10
        line_cycle(5, 5, 0);
        repeat (4) line_cycle(5, 5, 1);
        check("t1_min", min_period, 10);
        check("t1_max", max_period, 10);
        check("t1_edge_count", edge_count, 5);

        // 2: periods 8, 12, 6
        line_cycle(4, 4, 1);
        line_cycle(6, 6, 1);
        line_cycle(3, 3, 1);
        line_cycle(5, 5, 1);
        check("t2_period", period, 6);
        check("t2_min", min_period, 6);
        check("t2_max", max_period, 12);
        check("t2_edge_count", edge_count, 9);

        // 3: line held high until stuck
        exp_q.push_back(16'(last_gap));
        line_in = 1'b1;
        k = 0;
        while (!rise_pulse && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t3_rise_seen", rise_pulse, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!stuck && k < TO + 10);
        check("t3_stuck_latency", k, TO);
        check("t3_stuck_level", stuck_level, 1);
        repeat (5) @(negedge clk);
        check("t3_stuck_held", stuck, 1);
        line_in = 1'b0;
        repeat (3) @(negedge clk);
        line_cycle(4, 4, 0);
        line_cycle(5, 5, 1);
        check("t3_stuck_cleared", stuck, 0);
        check("t3_period", period, 8);
        check("t3_edge_count", edge_count, 12);
        check("t3_max", max_period, 12);

        // 4: clear_stats coincident with a period-9 measurement
        line_cycle(5, 4, 1);
        exp_q.push_back(16'd9);
        line_in = 1'b1;
        k = 0;
        while (!period_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t4_pv_seen", period_valid, 1);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("t4_min", min_period, 9);
        check("t4_max", max_period, 9);
        check("t4_edge_count", edge_count, 1);

        // 5: reset mid-period, counter at 5
        line_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rise_pulse", rise_pulse, 0);
        check("t5_period_valid", period_valid, 0);
        check("t5_period", period, 0);
        check("t5_min", min_period, 16'hffff);
        check("t5_max", max_period, 0);
        check("t5_edge_count", edge_count, 0);
        check("t5_stuck", stuck, 0);
        check("t5_stuck_level", stuck_level, 0);
        rst = 1'b0;
        line_cycle(5, 5, 0);
        line_cycle(6, 6, 1);
        check("t5_period_after", period, 10);
        check("t5_min_after", min_period, 10);
        check("t5_edge_count_after", edge_count, 2);

        // 6: enable dropped while stuck
        exp_q.push_back(16'(last_gap));
        line_in = 1'b1;
        k = 0;
        while (!stuck && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_stuck", stuck, 1);
        enable = 1'b0;
        @(negedge clk);
        check("t6_stuck_off", stuck, 0);
        check("t6_edge_count", edge_count, 3);
        check("t6_min", min_period, 10);
        check("t6_max", max_period, 12);
        check("t6_period", period, 12);
        line_in = 1'b0;
        repeat (4) @(negedge clk);
        line_in = 1'b1;
        nrise = 0;
        repeat (8) begin
            @(negedge clk);
            if (rise_pulse) nrise++;
        end
        check("t6_idle_rise_pulses", nrise, 1);
        check("t6_idle_edge_count", edge_count, 3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
